// File: rtl/aurora_pkg.sv
// Shared constants and types for the Aurora-style simplex TX channel.
// Ordered-set characters, init states and a lane popcount helper.
package aurora_pkg;

  localparam logic [7:0] K_IDLE_K = 8'hBC;
  localparam logic [7:0] K_R      = 8'h1C;
  localparam logic [7:0] K_A      = 8'h7C;
  localparam logic [7:0] K_V      = 8'hE8;
  localparam logic [7:0] K_CC     = 8'hF7;

  typedef enum logic [2:0] {
    RESET,
    ALIGN,
    BOND,
    VERIFY,
    READY
  } tx_init_state_t;

  function automatic int unsigned popcount(input logic [7:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/aurora_tx_channel_if.sv
// AXI-stream style beat handshake into the TX channel.
// Master drives data/valid, slave returns ready.
interface aurora_tx_channel_if #(
  parameter int NUM_LANES = 4
);

  logic [NUM_LANES*8-1:0] tdata;
  logic                   tvalid;
  logic                   tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );

endinterface

// File: rtl/aurora_cc_timer.sv
// Clock-compensation scheduler: CC_PERIOD open cycles, then a
// CC_LEN-cycle burst; cleared whenever enable drops.
module aurora_cc_timer #(
  parameter int CC_PERIOD = 5000,
  parameter int CC_LEN    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic cc_active
);

  localparam int TOTAL = CC_PERIOD + CC_LEN;
  localparam int W     = $clog2(TOTAL);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      r_cnt <= '0;
    end else if (r_cnt == W'(TOTAL - 1)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign cc_active = (r_cnt >= W'(CC_PERIOD));

endmodule

// File: rtl/aurora_tx_channel.sv
// Simplex Aurora-style TX channel front end: init sequencing,
// lane-mask striping of beats, idle and CC ordered-set insertion.
module aurora_tx_channel
  import aurora_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int CC_PERIOD = 5000,
  parameter int CC_LEN    = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_LANES-1:0]   lane_mask,
  aurora_tx_channel_if.slave     s,
  input  logic                   simplex_aligned,
  input  logic                   simplex_bonded,
  input  logic                   simplex_verified,
  input  logic                   simplex_reset,
  output logic                   channel_up,
  output logic [NUM_LANES*8-1:0] tx_data,
  output logic [NUM_LANES-1:0]   tx_k
);

  tx_init_state_t r_state;
  tx_init_state_t w_next;

  logic [NUM_LANES-1:0]   r_mask;
  logic                   w_cc_active;
  logic                   w_accept;
  int unsigned            w_n_active;
  logic [NUM_LANES*8-1:0] w_stripe;
  logic [7:0]             w_byte;
  logic                   w_k;
  logic                   w_data_sel;
  logic [NUM_LANES*8-1:0] w_tx_data;
  logic [NUM_LANES-1:0]   w_tx_k;
  logic [3:0]             w_idx;

  assign w_n_active = popcount(8'(r_mask));
  assign channel_up = (r_state == READY);
  assign s.tready   = (r_state == READY) && !w_cc_active;
  assign w_accept   = s.tvalid && s.tready;

  aurora_cc_timer #(
    .CC_PERIOD (CC_PERIOD),
    .CC_LEN    (CC_LEN)
  ) u_cc_timer (
    .clk       (clk),
    .rst       (rst),
    .enable    (r_state == READY),
    .cc_active (w_cc_active)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RESET;
      r_mask  <= '0;
      tx_data <= '0;
      tx_k    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == RESET) begin
        r_mask <= (lane_mask == '0) ? NUM_LANES'(1) : lane_mask;
      end
      tx_data <= w_tx_data;
      tx_k    <= w_tx_k;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      RESET:  w_next = ALIGN;
      ALIGN:  if (simplex_aligned)
                w_next = (w_n_active == 1) ? VERIFY : BOND;
      BOND:   if (simplex_bonded) w_next = VERIFY;
      VERIFY: if (simplex_verified) w_next = READY;
      READY:  w_next = READY;
      default: w_next = RESET;
    endcase
    if (simplex_reset) w_next = RESET;
  end

  // Byte b of the beat lands on the b-th active lane, counting upward.
  always_comb begin
    w_stripe = '0;
    w_idx    = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (r_mask[l]) begin
        w_stripe[l*8 +: 8] = s.tdata[8*w_idx +: 8];
        w_idx = w_idx + 4'd1;
      end
    end
  end

  always_comb begin
    w_byte     = 8'h00;
    w_k        = 1'b0;
    w_data_sel = 1'b0;
    unique case (r_state)
      ALIGN:  begin w_byte = K_IDLE_K; w_k = 1'b1; end
      BOND:   begin w_byte = K_A;      w_k = 1'b1; end
      VERIFY: begin w_byte = K_V;      w_k = 1'b1; end
      READY: begin
        if (w_cc_active) begin
          w_byte = K_CC;
          w_k    = 1'b1;
        end else if (w_accept) begin
          w_data_sel = 1'b1;
        end else begin
          w_byte = K_R;
          w_k    = 1'b1;
        end
      end
      default: ;
    endcase

    w_tx_data = '0;
    w_tx_k    = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (r_mask[l]) begin
        w_tx_data[l*8 +: 8] = w_data_sel ? w_stripe[l*8 +: 8] : w_byte;
        w_tx_k[l]           = w_k;
      end
    end
    // A re-init request discards whatever was about to go out.
    if (simplex_reset) begin
      w_tx_data = '0;
      w_tx_k    = '0;
    end
  end

endmodule
